// File: rtl/coin_pulse_gen.sv
// Purpose : condition the two raw coin-slot switches into clean one-cycle coin pulses.
// Latency : pulse registered CNT_MAX+2 sys_clk edges after the first edge that samples the key low.
// Backpr. : none; pulses are fire-and-forget, and a simultaneous half coin is deferred one cycle.
//
// Ports:
//   sys_clk        system clock, rising edge
//   sys_rst_n      asynchronous active-low reset
//   key_one        raw 1-yuan switch, active-low, asynchronous to sys_clk
//   key_half       raw 0.5-yuan switch, active-low, asynchronous to sys_clk
//   po_money_one   one-cycle pulse per accepted 1-yuan coin
//   po_money_half  one-cycle pulse per accepted 0.5-yuan coin

// Purpose : synchronise and debounce one active-low switch, flag debounced presses.
// Latency : ev asserted combinationally in the cycle before the debounced level flips.
// Backpr. : none.
//
// Ports:
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   key                 raw active-low switch
//   ev                  high for one cycle when a debounced press (1 -> 0) is accepted
module coin_debounce #(
  parameter int unsigned CNT_MAX = 20'd999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic ev
);

  localparam int unsigned CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;

  // The synchroniser resets to "released" so a key held through reset
  // is seen as a fresh press once reset lifts.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      // Any cycle agreeing with the debounced level restarts the window,
      // so a bounce anywhere inside it costs a full new window.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Only the falling (press) transition produces an event; release is silent.
  assign ev = (s2 != stable) && (cnt == CNT_LAST) && !s2;

endmodule

module coin_pulse_gen #(
  parameter int unsigned CNT_MAX = 20'd999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_one,
  input  logic key_half,
  output logic po_money_one,
  output logic po_money_half
);

  logic ev_one;
  logic ev_half;
  logic pending_half;

  coin_debounce #(.CNT_MAX(CNT_MAX)) u_deb_one (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (key_one),
    .ev        (ev_one)
  );

  coin_debounce #(.CNT_MAX(CNT_MAX)) u_deb_half (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (key_half),
    .ev        (ev_half)
  );

  // The 1-yuan coin wins a same-cycle collision; the half coin is parked in
  // pending_half and issued on the following edge. With a debounce window of
  // at least two cycles a second ev_half cannot arrive while one is parked.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      po_money_one  <= 1'b0;
      po_money_half <= 1'b0;
      pending_half  <= 1'b0;
    end else begin
      po_money_one <= ev_one;
      if (ev_one && ev_half) begin
        po_money_half <= 1'b0;
        pending_half  <= 1'b1;
      end else if (pending_half) begin
        po_money_half <= 1'b1;
        pending_half  <= 1'b0;
      end else begin
        po_money_half <= ev_half;
      end
    end
  end

endmodule

// File: doc/coin_pulse_gen.md
Name: coin_pulse_gen

Overview:
- Upstream input stage for the vending machine.
- Conditions two raw coin-slot switches (1-yuan, 0.5-yuan): 2-flop synchronisation, counter-based debounce, press-edge detection.
- Outputs single-cycle, mutually exclusive coin pulses that drive the vending machine's pi_money_one / pi_money_half inputs directly.

Parameters:
- CNT_MAX, 20'd999_999, debounce window in sys_clk cycles (20 ms at 50 MHz). Legal range is 2 or more; simulation uses 20.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge
- sys_rst_n  input  1  reset, asynchronous, active-low
- key_one  input  1  raw 1-yuan slot switch, asynchronous, active-low (0 = coin present)
- key_half  input  1  raw 0.5-yuan slot switch, asynchronous, active-low
- po_money_one  output  1  one-cycle pulse per accepted 1-yuan coin
- po_money_half  output  1  one-cycle pulse per accepted 0.5-yuan coin

Behaviour:
- Reset (sys_rst_n=0, asynchronous): all of the following take their reset values immediately.
  - Sync flops = 1 (released).
  - Debounced level stable_x = 1.
  - Counters = 0.
  - pending_half = 0.
  - po_money_one = po_money_half = 0.
- Per channel x in {one, half}, two identical instances:
  - Synchroniser: key_x -> s1_x -> s2_x, two flops, reset value 1.
  - Counter cnt_x, width $clog2(CNT_MAX):
    - if s2_x == stable_x: cnt_x <= 0
    - else if cnt_x == CNT_MAX-1: stable_x <= s2_x, cnt_x <= 0
    - else: cnt_x <= cnt_x + 1
  - Any single cycle with s2_x == stable_x (bounce) restarts the window from 0. The counter never wraps.
  - Press event ev_x (combinational) = (s2_x != stable_x) && (cnt_x == CNT_MAX-1) && (s2_x == 0).
  - Release (stable 0 -> 1) produces no event.
- Latency: key_x falls and then stays low. Count the first rising edge that samples it low as edge 1. The pulse is registered at edge CNT_MAX+2 and stays high for exactly one cycle.
- One pulse per press. Holding the key low indefinitely gives no further pulses. A new pulse requires a debounced release followed by a debounced press.
- Output arbitration (registered):
  - ev_one only: po_money_one <= 1.
  - ev_half only: if pending_half=0, po_money_half <= 1.
  - ev_one and ev_half in the same cycle: po_money_one <= 1 and pending_half <= 1. On the next edge po_money_half <= 1 and pending_half <= 0.
  - po_money_one and po_money_half are never both 1 in the same cycle.
  - No coin is ever lost. Because CNT_MAX >= 2, a new ev_half cannot coincide with pending_half=1.
- Reset mid-debounce: the partial count is discarded and no pulse is issued.
  - If a key is still held low when reset deasserts, it counts as a fresh press. Its pulse is registered at edge CNT_MAX+2 after deassertion (reset values of the sync flops are 1).
- Reset asserted while a pulse or pending_half is active: the outputs clear immediately and the pending coin is dropped.
- Outputs come straight from flops; there is no combinational path from any input.

Test Plan:
- Clean press, CNT_MAX=20: key_one low at edge 1, held 40 cycles -> po_money_one=1 for exactly one cycle, registered at edge 22; po_money_half stays 0 throughout.
- Bounce: key_half toggles every 3 cycles for 30 cycles, then stays low -> no pulse during bounce; a single po_money_half pulse 22 edges after the final falling edge.
- Short glitch: key_one low for 10 cycles then high -> no pulse. A later release of key_one produces no pulse either.
- Simultaneous: key_one and key_half fall on the same edge -> po_money_one at edge 22, po_money_half at edge 23, never overlapping.
- Hold and repeat: key_one held low 200 cycles -> exactly 1 pulse; release for 30 cycles, press again -> exactly a second pulse.
- Reset: assert sys_rst_n=0 at cycle 10 of a key_half press, deassert 5 cycles later with key held -> outputs 0 immediately on assertion; one po_money_half pulse 22 edges after deassertion.
